demux_1to8_buf: RTL
===================

DEMUX_1TO8_BUF -- requirements
Module: demux_1to8_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data width of each channel.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the delivered-word counter.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, with all state updating on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: the reset, which is asynchronous and active-low.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: the upstream word is present.
REQ-006 Port in_ready SHALL be an output, 1 bit wide: the block accepts the word this cycle.
REQ-007 Port in_sel SHALL be an input, 3 bits wide: the destination channel index, 0 to 7.
REQ-008 Port in_data SHALL be an input, DATA_W bits wide: the upstream word.
REQ-009 Port out_valid SHALL be an output, 8 bits wide: bit k means channel k holds a word.
REQ-010 Port out_ready SHALL be an input, 8 bits wide: bit k means the channel k consumer takes its word.
REQ-011 Port out_data SHALL be an output, 8*DATA_W bits wide: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 Port xfer_count SHALL be an output, CNT_W bits wide: a wrapping count of completed output transfers.
REQ-013 Port in_bcast SHALL be an input, 1 bit wide: a broadcast request, present only when DEMUX_BCAST_EN is defined.

Function
REQ-014 Each channel k SHALL have a one-entry holding register with a two-state FSM, EMPTY or FULL, and out_valid[k] SHALL be 1 exactly when the channel is FULL.
REQ-015 An input accept SHALL occur when in_valid and in_ready are both 1 at a rising clk edge.
REQ-016 The unicast in_ready SHALL equal (channel in_sel is EMPTY) OR (out_ready[in_sel] is 1), which allows a same-cycle drain and refill with no bubble.
REQ-017 in_ready SHALL be combinational from the state, in_sel and out_ready only, and SHALL NOT depend on in_valid.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N SHALL appear with out_valid set after edge N.
REQ-019 An output transfer on channel k SHALL occur when out_valid[k] and out_ready[k] are both 1 at an edge.
REQ-020 After an output transfer on channel k, the channel SHALL go to EMPTY unless it is refilled at the same edge, in which case it SHALL stay FULL with the new word.
REQ-021 While out_valid[k]=1 and out_ready[k]=0, out_data for channel k SHALL hold stable.
REQ-022 A channel that is EMPTY SHALL output out_data = 0.
REQ-023 Channels SHALL be independent: a stall on one channel SHALL NOT block accepts destined for other channels.
REQ-024 xfer_count SHALL increment by the number of channels that complete an output transfer at each edge (0 to 8), modulo 2^CNT_W.
REQ-025 At wrap-around, xfer_count SHALL roll from all-ones back to 0 plus the remaining increment, and SHALL raise no flag.
REQ-026 When in_valid=0, in_sel and in_data SHALL be ignored.
REQ-027 A word SHALL never be duplicated, dropped or reordered within a channel.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately, without waiting for a clock edge, force every channel to EMPTY, out_valid=0, out_data=0 and xfer_count=0.
REQ-029 While rst_n=0, in_ready SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard all held words, and no transfer SHALL be counted at that edge.
REQ-031 The first accept after reset SHALL be possible at the first rising edge with rst_n=1.

Configuration
REQ-032 When macro DEMUX_BCAST_EN is defined, port in_bcast SHALL exist.
REQ-033 With DEMUX_BCAST_EN defined and in_bcast=1, in_ready SHALL equal the AND over all k of (EMPTY or out_ready[k]), and an accept SHALL load in_data into all 8 channels, ignoring in_sel.
REQ-034 With DEMUX_BCAST_EN defined and in_bcast=0, behaviour SHALL be the unicast behaviour defined above.
REQ-035 When DEMUX_BCAST_EN is not defined, the in_bcast port and its logic SHALL be absent, and behaviour SHALL be unicast only.

Verification
REQ-036 Reset then send sel=3, data=0xDEADBEEF with out_ready=0 -> the next cycle out_valid=0x08, channel 3 data=0xDEADBEEF, and it stays stable for 5 stalled cycles.
REQ-037 With channel 3 FULL, out_ready[3]=1 and a new accept to sel=3 with data=0x12345678 -> in_ready=1, channel 3 shows 0x12345678 next cycle, and xfer_count increments by 1.
REQ-038 With channel 5 FULL and stalled, send to sel=5 and then sel=0 -> in_ready=0 for sel=5, in_ready=1 for sel=0, and channel 0 delivers.
REQ-039 Preload xfer_count to 0xFFFE, then complete transfers on channels 1, 2 and 4 at one edge -> xfer_count=0x0001.
REQ-040 With channels 2 and 6 FULL, drop rst_n between clock edges -> out_valid=0x00 and xfer_count=0 immediately.
REQ-041 With DEMUX_BCAST_EN defined, in_bcast=1, data=0xA5A5A5A5 and all channels EMPTY -> out_valid=0xFF and all 8 channels show 0xA5A5A5A5.

Source files
------------

// File: rtl/demux_1to8_buf.sv
// demux_1to8_buf: 1-to-8 demultiplexer with a one-entry holding register per channel.
// Each channel drains and refills in the same cycle, so a streaming consumer sees no bubble.
// xfer_count counts completed output transfers and wraps silently.
// Optional feature: define DEMUX_BCAST_EN to add in_bcast, which loads one word into all
// eight channels at once.
module demux_1to8_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_sel,
    input  logic [DATA_W-1:0]   in_data,
`ifdef DEMUX_BCAST_EN
    input  logic                in_bcast,
`endif
    output logic [7:0]          out_valid,
    input  logic [7:0]          out_ready,
    output logic [8*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]    xfer_count
);

    typedef enum logic {StEmpty, StFull} ch_state_e;

    ch_state_e         state_q [8];
    ch_state_e         state_d [8];
    logic [DATA_W-1:0] data_q  [8];
    logic [DATA_W-1:0] data_d  [8];
    logic [CNT_W-1:0]  xfer_count_q;
    logic [CNT_W-1:0]  xfer_count_d;

    logic [7:0] room;    // channel can take a word at the next edge
    logic [7:0] load;
    logic [7:0] xfer;
    logic [3:0] n_xfer;
    logic       accept;

    // Accept decision: a channel has room if empty or being drained this cycle.
    always_comb begin
        room = '0;
        for (int k = 0; k < 8; k++) begin
            room[k] = (state_q[k] == StEmpty) || out_ready[k];
        end
`ifdef DEMUX_BCAST_EN
        if (in_bcast) begin
            in_ready = rst_n && (&room);
        end else begin
            in_ready = rst_n && room[in_sel];
        end
`else
        in_ready = rst_n && room[in_sel];
`endif
        accept = in_valid && in_ready;
        load   = '0;
        if (accept) begin
`ifdef DEMUX_BCAST_EN
            load = in_bcast ? 8'hFF : (8'b1 << in_sel);
`else
            load = 8'b1 << in_sel;
`endif
        end
    end

    // Per-channel next state: a refill wins over a drain so the channel stays full.
    always_comb begin
        xfer   = '0;
        n_xfer = '0;
        for (int k = 0; k < 8; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            xfer[k]    = (state_q[k] == StFull) && out_ready[k];
            n_xfer     = n_xfer + {3'b000, xfer[k]};
            if (load[k]) begin
                state_d[k] = StFull;
                data_d[k]  = in_data;
            end else if (xfer[k]) begin
                // Clearing on drain keeps an empty channel's output at zero.
                state_d[k] = StEmpty;
                data_d[k]  = '0;
            end
        end
        xfer_count_d = xfer_count_q + CNT_W'(n_xfer);
    end

    // State, data and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                state_q[k] <= StEmpty;
                data_q[k]  <= '0;
            end
            xfer_count_q <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
            xfer_count_q <= xfer_count_d;
        end
    end

    // Flatten the channel registers onto the output buses.
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < 8; k++) begin
            out_valid[k]                   = (state_q[k] == StFull);
            out_data[k*DATA_W +: DATA_W]   = data_q[k];
        end
    end

    assign xfer_count = xfer_count_q;

endmodule
